// File: rtl/cmd_arbiter_pkg.sv
// Shared command-word layout and sizing for the master-side command path.
// The command/response FIFOs and the memory-controller side use the same field map.
package cmd_arbiter_pkg;

    localparam int unsigned CMD_W    = 17;
    localparam int unsigned OP_BIT   = 16;
    localparam int unsigned ADDR_MSB = 15;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned DATA_W   = DATA_MSB - DATA_LSB + 1;
    localparam int unsigned RSP_W    = 8;

    localparam int unsigned DEF_TAG_DEPTH = 16;
    localparam int unsigned DEF_CNT_W     = $clog2(DEF_TAG_DEPTH) + 1;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    function automatic logic is_write(input cmd_t cmd);
        return cmd.op == OP_WRITE;
    endfunction

    function automatic logic is_read(input cmd_t cmd);
        return cmd.op == OP_READ;
    endfunction

endpackage

// File: rtl/tag_queue.sv
// Synchronous FIFO of 1-bit requester IDs, one entry per outstanding read.
// Pointers carry one extra bit so full/empty fall out of a plain subtraction.
module tag_queue #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       push_id,
    input  logic                       pop,
    output logic                       pop_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer update; the caller never pushes when full or pops when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_id;
        end
    end

    always_comb begin
        count  = wr_ptr - rd_ptr;
        full   = (count == PTR_W'(DEPTH));
        empty  = (count == '0);
        pop_id = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin merge of two requesters onto the command FIFO, with read-tag
// tracking so each response word is routed back to the requester that asked.
module cmd_arbiter
    import cmd_arbiter_pkg::*;
#(
    parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [CMD_W-1:0]   req0_cmd,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [CMD_W-1:0]   req1_cmd,
    output logic               req1_ready,
    output logic               cmd_fifo_wr_en,
    output logic [CMD_W-1:0]   cmd_fifo_data,
    input  logic               cmd_fifo_full,
    output logic               resp_fifo_rd_en,
    input  logic [RSP_W-1:0]   resp_fifo_data,
    input  logic               resp_fifo_empty,
    output logic               rsp0_valid,
    output logic [RSP_W-1:0]   rsp0_data,
    output logic               rsp1_valid,
    output logic [RSP_W-1:0]   rsp1_data,
    output logic [CNT_W-1:0]   outstanding,
    output logic               err_orphan
);

    cmd_t req0_c;
    cmd_t req1_c;
    cmd_t issued_c;

    logic last_grant;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    logic tq_push;
    logic tq_pop;
    logic tq_pop_id;
    logic tq_full;
    logic tq_empty;
    logic orphan;

    assign req0_c = cmd_t'(req0_cmd);
    assign req1_c = cmd_t'(req1_cmd);

    // Reads wait on a full tag queue; writes never do, so they can bypass a stalled read.
    always_comb begin
        elig0 = req0_valid & (is_write(req0_c) | ~tq_full);
        elig1 = req1_valid & (is_write(req1_c) | ~tq_full);
    end

    // Grant: a sole eligible requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && !cmd_fifo_full) begin
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Zero-latency pass-through of the granted command.
    always_comb begin
        req0_ready     = grant0;
        req1_ready     = grant1;
        cmd_fifo_wr_en = grant0 | grant1;
        issued_c       = '0;
        if (grant0) begin
            issued_c = req0_c;
        end else if (grant1) begin
            issued_c = req1_c;
        end
        cmd_fifo_data  = CMD_W'(issued_c);
        tq_push        = cmd_fifo_wr_en & is_read(issued_c);
    end

    // Every available response word is popped; it is matched only if a tag is waiting.
    always_comb begin
        resp_fifo_rd_en = ~rst & ~resp_fifo_empty;
        tq_pop          = resp_fifo_rd_en & ~tq_empty;
        orphan          = resp_fifo_rd_en & tq_empty;
    end

    tag_queue #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (tq_push),
        .push_id (grant1),
        .pop     (tq_pop),
        .pop_id  (tq_pop_id),
        .full    (tq_full),
        .empty   (tq_empty),
        .count   (outstanding)
    );

    // Response routing, arbitration history and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp0_valid <= tq_pop & ~tq_pop_id;
            rsp1_valid <= tq_pop & tq_pop_id;
            if (tq_pop && !tq_pop_id) begin
                rsp0_data <= resp_fifo_data;
            end
            if (tq_pop && tq_pop_id) begin
                rsp1_data <= resp_fifo_data;
            end
            if (orphan) begin
                err_orphan <= 1'b1;
            end
            if (cmd_fifo_wr_en) begin
                last_grant <= grant1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: arbitration order, tag routing, tag-full
// bypass, command-FIFO backpressure, orphan responses and mid-traffic reset.
module tb_cmd_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [16:0] req0_cmd;
    logic        req0_ready;
    logic        req1_valid;
    logic [16:0] req1_cmd;
    logic        req1_ready;
    logic        cmd_fifo_wr_en;
    logic [16:0] cmd_fifo_data;
    logic        cmd_fifo_full;
    logic        resp_fifo_rd_en;
    logic [7:0]  resp_fifo_data;
    logic        resp_fifo_empty;
    logic        rsp0_valid;
    logic [7:0]  rsp0_data;
    logic        rsp1_valid;
    logic [7:0]  rsp1_data;
    logic [4:0]  outstanding;
    logic        err_orphan;

    int checks;
    int errors;

    cmd_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_cmd        (req0_cmd),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_cmd        (req1_cmd),
        .req1_ready      (req1_ready),
        .cmd_fifo_wr_en  (cmd_fifo_wr_en),
        .cmd_fifo_data   (cmd_fifo_data),
        .cmd_fifo_full   (cmd_fifo_full),
        .resp_fifo_rd_en (resp_fifo_rd_en),
        .resp_fifo_data  (resp_fifo_data),
        .resp_fifo_empty (resp_fifo_empty),
        .rsp0_valid      (rsp0_valid),
        .rsp0_data       (rsp0_data),
        .rsp1_valid      (rsp1_valid),
        .rsp1_data       (rsp1_data),
        .outstanding     (outstanding),
        .err_orphan      (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req0_cmd = 17'h110A5;
        resp_fifo_empty = 1'b0;
        resp_fifo_data = 8'h99;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        checks++; if (cmd_fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", cmd_fifo_wr_en); end
        checks++; if (resp_fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", resp_fifo_rd_en); end
        step();
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        resp_fifo_empty = 1'b1;
        #1;
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b want 0", err_orphan); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
        checks++; if ({rsp0_data, rsp1_data} !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", {rsp0_data, rsp1_data}); end
    endtask

    task automatic test_writes();
        logic        exp0;
        logic [16:0] exp_data;
        req0_valid = 1'b1;
        req0_cmd = 17'h110A5;
        req1_valid = 1'b1;
        req1_cmd = 17'h1205A;
        for (int i = 0; i < 4; i++) begin
            exp0 = (i % 2) == 0;
            exp_data = exp0 ? 17'h110A5 : 17'h1205A;
            #1;
            checks++; if ({req0_ready, req1_ready} !== {exp0, ~exp0}) begin errors++; $display("FAIL wr_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, {exp0, ~exp0}); end
            checks++; if (cmd_fifo_wr_en !== 1'b1 || cmd_fifo_data !== exp_data) begin errors++; $display("FAIL wr_data[%0d]: got en=%b %h want en=1 %h", i, cmd_fifo_wr_en, cmd_fifo_data, exp_data); end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL wr_outstanding: got %0d want 0", outstanding); end
        checks++; if (cmd_fifo_wr_en !== 1'b0 || cmd_fifo_data !== 17'h0) begin errors++; $display("FAIL wr_idle: got en=%b %h want en=0 00000", cmd_fifo_wr_en, cmd_fifo_data); end
    endtask

    task automatic test_reads();
        req0_valid = 1'b1;
        req0_cmd = 17'h01000;
        #1;
        checks++; if (req0_ready !== 1'b1 || cmd_fifo_data !== 17'h01000) begin errors++; $display("FAIL rd_issue0: got rdy=%b %h want rdy=1 01000", req0_ready, cmd_fifo_data); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_cmd = 17'h02000;
        #1;
        checks++; if (req1_ready !== 1'b1 || cmd_fifo_data !== 17'h02000) begin errors++; $display("FAIL rd_issue1: got rdy=%b %h want rdy=1 02000", req1_ready, cmd_fifo_data); end
        step();
        req1_valid = 1'b0;
        checks++; if (outstanding !== 5'd2) begin errors++; $display("FAIL rd_outstanding2: got %0d want 2", outstanding); end
        resp_fifo_empty = 1'b0;
        resp_fifo_data = 8'hA5;
        #1;
        checks++; if (resp_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rd_pop_en: got %b want 1", resp_fifo_rd_en); end
        step();
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_data !== 8'hA5) begin errors++; $display("FAIL rd_rsp0: got v=%b d=%h want v=10 d=a5", {rsp0_valid, rsp1_valid}, rsp0_data); end
        checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL rd_outstanding1: got %0d want 1", outstanding); end
        resp_fifo_data = 8'h5A;
        step();
        resp_fifo_empty = 1'b1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_data !== 8'h5A) begin errors++; $display("FAIL rd_rsp1: got v=%b d=%h want v=01 d=5a", {rsp0_valid, rsp1_valid}, rsp1_data); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL rd_outstanding0: got %0d want 0", outstanding); end
        step();
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rd_pulse_end: got %b want 00", {rsp0_valid, rsp1_valid}); end
    endtask

    task automatic test_tag_full();
        req0_valid = 1'b1;
        req0_cmd = 17'h01000;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL full_fill[%0d]: got %b want 1", i, req0_ready); end
            step();
        end
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", outstanding); end
        req1_valid = 1'b1;
        req1_cmd = 17'h13033;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL full_bypass: got %b want 01", {req0_ready, req1_ready}); end
        checks++; if (cmd_fifo_wr_en !== 1'b1 || cmd_fifo_data !== 17'h13033) begin errors++; $display("FAIL full_bypass_data: got en=%b %h want en=1 13033", cmd_fifo_wr_en, cmd_fifo_data); end
        step();
        req1_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL full_after_write: got %0d want 16", outstanding); end
    endtask

    task automatic test_full_pop();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_cmd = 17'h02100;
        resp_fifo_empty = 1'b0;
        resp_fifo_data = 8'h77;
        #1;
        checks++; if (req1_ready !== 1'b0 || resp_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL fp_stall: got rdy=%b rd_en=%b want rdy=0 rd_en=1", req1_ready, resp_fifo_rd_en); end
        step();
        resp_fifo_empty = 1'b1;
        #1;
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h77) begin errors++; $display("FAIL fp_rsp: got v=%b d=%h want v=1 d=77", rsp0_valid, rsp0_data); end
        checks++; if (outstanding !== 5'd15 || req1_ready !== 1'b1) begin errors++; $display("FAIL fp_grant: got cnt=%0d rdy=%b want cnt=15 rdy=1", outstanding, req1_ready); end
        step();
        req1_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL fp_refill: got %0d want 16", outstanding); end
        // Queue now holds fifteen requester-0 tags followed by one requester-1 tag.
        for (int i = 0; i < 16; i++) begin
            resp_fifo_empty = 1'b0;
            resp_fifo_data = 8'(8'h40 + i);
            step();
            if (i < 15) begin
                checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_data !== 8'(8'h40 + i)) begin errors++; $display("FAIL fp_drain[%0d]: got v=%b d=%h want v=10 d=%h", i, {rsp0_valid, rsp1_valid}, rsp0_data, 8'(8'h40 + i)); end
            end else begin
                checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_data !== 8'h4F) begin errors++; $display("FAIL fp_drain[%0d]: got v=%b d=%h want v=01 d=4f", i, {rsp0_valid, rsp1_valid}, rsp1_data); end
            end
        end
        resp_fifo_empty = 1'b1;
        #1;
        checks++; if (outstanding !== 5'd0 || err_orphan !== 1'b0) begin errors++; $display("FAIL fp_drained: got cnt=%0d err=%b want cnt=0 err=0", outstanding, err_orphan); end
        step();
    endtask

    task automatic test_fifo_full();
        cmd_fifo_full = 1'b1;
        req0_valid = 1'b1;
        req0_cmd = 17'h110A5;
        req1_valid = 1'b1;
        req1_cmd = 17'h1205A;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({req0_ready, req1_ready, cmd_fifo_wr_en} !== 3'b000) begin errors++; $display("FAIL ff_block[%0d]: got %b want 000", i, {req0_ready, req1_ready, cmd_fifo_wr_en}); end
            step();
        end
        cmd_fifo_full = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10 || cmd_fifo_data !== 17'h110A5) begin errors++; $display("FAIL ff_release0: got %b %h want 10 110a5", {req0_ready, req1_ready}, cmd_fifo_data); end
        step();
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01 || cmd_fifo_data !== 17'h1205A) begin errors++; $display("FAIL ff_release1: got %b %h want 01 1205a", {req0_ready, req1_ready}, cmd_fifo_data); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_orphan();
        resp_fifo_empty = 1'b0;
        resp_fifo_data = 8'hEE;
        #1;
        checks++; if (resp_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL orphan_pop: got %b want 1", resp_fifo_rd_en); end
        step();
        resp_fifo_empty = 1'b1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got v=%b err=%b want v=00 err=1", {rsp0_valid, rsp1_valid}, err_orphan); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL orphan_count: got %0d want 0", outstanding); end
        step();
        step();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1;
        req0_cmd = 17'h01000;
        step();
        checks++; if (outstanding !== 5'd1) begin errors++; $display("FAIL mid_pre: got %0d want 1", outstanding); end
        rst = 1'b1;
        resp_fifo_empty = 1'b0;
        resp_fifo_data = 8'h12;
        #1;
        checks++; if ({req0_ready, cmd_fifo_wr_en, resp_fifo_rd_en} !== 3'b000) begin errors++; $display("FAIL mid_forced: got %b want 000", {req0_ready, cmd_fifo_wr_en, resp_fifo_rd_en}); end
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        resp_fifo_empty = 1'b1;
        #1;
        checks++; if (outstanding !== 5'd0 || err_orphan !== 1'b0) begin errors++; $display("FAIL mid_state: got cnt=%0d err=%b want cnt=0 err=0", outstanding, err_orphan); end
        checks++; if ({rsp0_valid, rsp1_valid, rsp0_data, rsp1_data} !== 18'h0) begin errors++; $display("FAIL mid_rsp: got %h want 00000", {rsp0_valid, rsp1_valid, rsp0_data, rsp1_data}); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req0_valid = 1'b0;
        req0_cmd = '0;
        req1_valid = 1'b0;
        req1_cmd = '0;
        cmd_fifo_full = 1'b0;
        resp_fifo_data = '0;
        resp_fifo_empty = 1'b1;
        test_reset();
        test_writes();
        test_reads();
        test_tag_full();
        test_full_pop();
        test_fifo_full();
        test_orphan();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
